pkt_buffer: RTL and testbench



---
 rtl/pkt_buffer_pkg.sv | 24 ++
 rtl/sdp_ram.sv | 27 ++
 rtl/pkt_buffer.sv | 139 +++++++++++++
 tb/tb_pkt_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_buffer_pkg.sv
`default_nettype none
// ============================================================================
// pkt_buffer_pkg : shared pointer sizing, RAM word layout and write-FSM states
// Revision 1.0
// ============================================================================
package pkt_buffer_pkg;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_e;

  // One extra pointer bit distinguishes a full buffer from an empty one.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // RAM word is {last, data}; the last flag sits just above the payload.
  function automatic int last_bit(input int data_width);
    return data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// sdp_ram : simple dual-port RAM, one write port, one registered read port
// Revision 1.0
// ============================================================================
module sdp_ram #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* syn_ramstyle = "block_ram" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/pkt_buffer.sv
`default_nettype none
// ============================================================================
// pkt_buffer : store-and-forward frame buffer, speculative write with rollback
// Revision 1.0
// ============================================================================
module pkt_buffer
  import pkt_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_ok,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH:0]   level,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int PTR_W    = ptr_width(ADDR_WIDTH);
  localparam int LAST_BIT = last_bit(DATA_WIDTH);
  localparam int WORD_W   = DATA_WIDTH + 1;

  wr_state_e         state;
  logic [PTR_W-1:0]  wr_ptr, wr_commit, rd_ptr, used;
  logic              has_space, wr_en, drop, rd_en, rd_pend, pop;
  logic [WORD_W-1:0] wr_word, rd_word, skid0, skid1;
  logic [1:0]        skid_cnt;

  // used never exceeds DEPTH, so its top bit alone means "full".
  assign used      = wr_ptr - rd_ptr;
  assign has_space = ~used[ADDR_WIDTH];
  assign wr_en     = (state == ACCEPT) && in_valid && has_space;
  assign wr_word   = {in_last, in_data};
  assign drop      = in_valid && in_last && ((state == DISCARD) || !has_space || !in_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCEPT;
      wr_ptr    <= '0;
      wr_commit <= '0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            if (has_space) begin
              if (in_last && in_ok) begin
                wr_ptr    <= wr_ptr + 1'b1;
                wr_commit <= wr_ptr + 1'b1;
              end else if (in_last) begin
                wr_ptr <= wr_commit;
              end else begin
                wr_ptr <= wr_ptr + 1'b1;
              end
            end else if (in_last) begin
              wr_ptr <= wr_commit;
            end else begin
              state <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (in_valid && in_last) begin
            wr_ptr <= wr_commit;
            state  <= ACCEPT;
          end
        end
      endcase
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  sdp_ram #(
    .DATA_WIDTH (WORD_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_word)
  );

  // A read is allowed if the skid, after this cycle's pop and in-flight
  // return, still has a free slot for the new word.
  assign pop   = out_valid && out_ready;
  assign rd_en = (rd_ptr != wr_commit) &&
                 (({1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop}) < 3'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      rd_pend  <= 1'b0;
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({rd_pend, pop})
        2'b11: begin
          if (skid_cnt == 2'd2) begin
            skid0 <= skid1;
            skid1 <= rd_word;
          end else begin
            skid0 <= rd_word;
          end
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 1'b1;
        end
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= rd_word;
          else                  skid1 <= rd_word;
          skid_cnt <= skid_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (skid_cnt != 2'd0);
  assign out_data  = skid0[DATA_WIDTH-1:0];
  assign out_last  = skid0[LAST_BIT];
  assign level     = wr_commit - rd_ptr;

endmodule
`default_nettype wire

// File: tb/tb_pkt_buffer.sv
`default_nettype none
// ============================================================================
// tb_pkt_buffer : randomized scoreboard bench for pkt_buffer (ADDR_WIDTH = 4)
// Revision 1.0
// ============================================================================
module tb_pkt_buffer;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ok = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [AW:0]   level;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  pkt_buffer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ok     (in_ok),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  // Reference model: beats of every frame that must commit, in order.
  logic [DW:0] sb[$];
  logic [DW:0] exp_word;
  logic [DW:0] stall_word;
  int  n_vec = 0;
  int  n_err = 0;
  int  exp_drop = 0;
  int  ready_mode = 0;   // 0 = held high, 1 = held low, 2 = random
  bit  in_frame = 1'b0;
  bit  stall_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(1) == 1);
    endcase
  end

  // Monitor: inputs change at negedge, so values seen 2 units later are
  // exactly what the DUT samples at the following posedge.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stall_prev = 1'b0;
      in_frame   = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_last, out_data}, stall_word);
      end
      if (ready_mode == 0 && in_frame) check("no_bubble", out_valid, 1);
      stall_prev = out_valid && !out_ready;
      stall_word = {out_last, out_data};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", {out_last, out_data});
        end else begin
          exp_word = sb.pop_front();
          check("beat", {out_last, out_data}, exp_word);
        end
        in_frame = !out_last;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    sb.delete();
    exp_drop = 0;
    @(negedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_level", level, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
  endtask

  // base < 0 gives random payload, otherwise base, base+1, ...
  task automatic send_frame(input int len, input bit ok, input int base, input bit gaps);
    bit commit;
    int t;
    commit = ok && (len <= DEPTH);
    if (commit) begin
      t = 0;
      while ((sb.size() + len > DEPTH) && t < 5000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 5000) begin
        n_vec++;
        n_err++;
        $display("FAIL room_timeout: got %0d queued, expected <= %0d", sb.size(), DEPTH - len);
      end
    end
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (base < 0) ? DW'($urandom) : DW'(base + i);
      in_last  = (i == len - 1);
      in_ok    = (i == len - 1) ? ok : ($urandom_range(1) == 1);
      if (commit) sb.push_back({in_last, in_data});
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!commit) exp_drop++;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    #2;
    check({name, "_drained"}, sb.size(), 0);
    check({name, "_level"}, level, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_drop_cnt"}, drop_cnt, exp_drop);
  endtask

  initial begin
    apply_reset();

    // Single 5-beat frame, output exactly two cycles after the last beat.
    ready_mode = 0;
    send_frame(5, 1'b1, 1, 1'b0);
    #2;
    check("lat_edge_n", out_valid, 0);
    @(negedge clk); #2;
    check("lat_edge_n1", out_valid, 0);
    @(negedge clk); #2;
    check("lat_edge_n2", out_valid, 1);
    check("lat_first_data", out_data, 8'h01);
    wait_idle("single");

    // Good / bad / good frames.
    apply_reset();
    send_frame(3, 1'b1, 8'h10, 1'b0);
    send_frame(4, 1'b0, 8'h20, 1'b0);
    send_frame(2, 1'b1, 8'h30, 1'b0);
    wait_idle("abc");

    // Oversized frame with the reader stalled, then a full-depth frame.
    apply_reset();
    ready_mode = 1;
    send_frame(20, 1'b1, 8'h40, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    check("ovf_out_valid", out_valid, 0);
    check("ovf_level", level, 0);
    check("ovf_drop_cnt", drop_cnt, 1);
    send_frame(16, 1'b1, 8'h80, 1'b0);
    ready_mode = 0;
    wait_idle("full_depth");

    // Random backpressure on a 10-beat frame.
    ready_mode = 2;
    send_frame(10, 1'b1, -1, 1'b0);
    wait_idle("toggle");

    // Back-to-back 8-beat frames, pointers wrap many times.
    ready_mode = 0;
    for (int f = 0; f < 200; f++) send_frame(8, 1'b1, -1, 1'b0);
    wait_idle("stream");

    // Random lengths, status and gaps under random backpressure.
    ready_mode = 2;
    for (int f = 0; f < 60; f++)
      send_frame($urandom_range(20, 1), ($urandom_range(3) != 0), -1, 1'b1);
    wait_idle("random");

    // Reset in the middle of readout and of an incoming frame.
    ready_mode = 1;
    send_frame(8, 1'b1, -1, 1'b0);
    ready_mode = 2;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      in_last  = 1'b0;
    end
    apply_reset();
    ready_mode = 0;
    send_frame(6, 1'b1, -1, 1'b0);
    wait_idle("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
